inv_sbox_serial: RTL and testbench

//  Inverse SubBytes engine for the AES decryption datapath (FIPS-197 InvSubBytes).

---
 rtl/inv_sbox_serial.sv | 150 +++++++++++++++
 tb/tb_inv_sbox_serial.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sbox_serial.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox_serial
// Description : Serial AES InvSubBytes engine. Accepts a 128-bit state over a
//               valid/ready handshake, substitutes BYTES_PER_CYCLE bytes per
//               clock through a 256-entry inverse S-box, and returns the
//               result over a second valid/ready handshake.
//
// Ports       : clk        rising-edge clock
//               rst_n      synchronous reset, active low
//               in_valid   in_state is valid
//               in_ready   block can accept a state (high only in IDLE)
//               in_state   input state, byte 0 = [127:120] .. byte 15 = [7:0]
//               out_valid  out_state holds a completed result
//               out_ready  downstream accepts out_state
//               out_state  InvSubBytes(in_state), same byte ordering
//               busy       high while a state is being processed or held
//
// Revision    : 1.0  initial release
// ============================================================================
module inv_sbox_serial #(
    parameter int BYTES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Only divisors of 16 give an integral number of RUN cycles.
    generate
        if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
              BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
            $error("inv_sbox_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam int c_ncyc = 16 / BYTES_PER_CYCLE;
    localparam int c_cw   = (c_ncyc > 1) ? $clog2(c_ncyc) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(c_ncyc - 1);

    // FIPS-197 inverse S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_lookup(input logic [7:0] b);
        return c_inv_sbox[2047 - 8 * int'(b) -: 8];
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [c_cw-1:0]   r_cnt;
    logic [127:0]      r_work;
    logic [127:0]      w_work_next;
    logic [127:0]      r_out_state;
    logic              r_out_valid;

    // Substitute the slice of bytes selected by the counter; all other bytes
    // pass through unchanged.
    always_comb begin
        w_work_next = r_work;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            w_work_next[127 - 8 * (int'(r_cnt) * BYTES_PER_CYCLE + k) -: 8] =
                inv_lookup(r_work[127 - 8 * (int'(r_cnt) * BYTES_PER_CYCLE + k) -: 8]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)         w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == c_last)  w_state_next = ST_DONE;
            ST_DONE: if (out_ready)        w_state_next = ST_IDLE;
            default:                       w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_work      <= '0;
            r_out_state <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_work <= in_state;
                        r_cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_next;
                    if (r_cnt == c_last) begin
                        // Counter is parked at zero rather than wrapping.
                        r_cnt       <= '0;
                        r_out_state <= w_work_next;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_state = r_out_state;

endmodule
`default_nettype wire

// File: tb/tb_inv_sbox_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_sbox_serial
// Description : Self-checking bench for inv_sbox_serial. Builds its own
//               forward and inverse S-box from GF(2^8) arithmetic and checks
//               a BPC=1 instance and a BPC=4 instance against it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_inv_sbox_serial;

    logic         clk = 1'b0;
    logic         rst_n;
    always #5 clk = ~clk;

    // BPC = 1 instance
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_state, a_out_state;
    // BPC = 4 instance
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_state, b_out_state;

    inv_sbox_serial #(.BYTES_PER_CYCLE(1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_state  (a_in_state),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_state (a_out_state),
        .busy      (a_busy)
    );

    inv_sbox_serial #(.BYTES_PER_CYCLE(4)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_state  (b_in_state),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_state (b_out_state),
        .busy      (b_busy)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] a = x;
        logic [7:0] b = y;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15 - n -: 8];
    endfunction

    task automatic build_tables();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] map_state(input logic [127:0] s, input bit inverse);
        logic [127:0] r;
        for (int i = 0; i < 16; i++)
            r[127 - 8 * i -: 8] = inverse ? inv_tab[s[127 - 8 * i -: 8]] : fwd_tab[s[127 - 8 * i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- instance A helpers ----------------
    task automatic a_accept(input string tag, input logic [127:0] s);
        int n = 0;
        @(negedge clk);
        while (!a_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 128'(a_in_ready), 128'd1);
        a_in_valid = 1'b1;
        a_in_state = s;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        a_in_state = rand128();
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic a_wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!a_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    endtask

    task automatic a_run(input string tag, input logic [127:0] s, input logic [127:0] exp);
        a_accept(tag, s);
        a_wait_done(tag, 16);
        check({tag, "_data"}, a_out_state, exp);
        @(negedge clk);
        check({tag, "_drain"}, {126'd0, a_out_valid, a_in_ready}, 128'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] p, hold;
        logic [7:0]   salt;
        int           lat, seen;

        build_tables();
        rst_n       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_state  = rand128();
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_state  = '0;
        b_out_ready = 1'b1;

        // 1: reset with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", {a_out_valid, a_busy, a_out_state}, 130'd0);
        rst_n      = 1'b1;
        a_in_valid = 1'b0;
        check("rst_in_ready", 128'(a_in_ready), 128'd1);
        @(negedge clk);
        check("rst_no_capture", {126'd0, a_busy, a_out_valid}, 128'd0);

        // 2: known vector
        a_run("known", 128'hd46ea57cdf4921c363007c6363636363,
                       128'h19452901efa47b330052010000000000);

        // 3: round trip through the forward S-box, every byte value covered
        salt = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) p[127 - 8 * j -: 8] = 8'(i * 16 + j) ^ salt;
            a_run($sformatf("rt_all%0d", i), map_state(p, 1'b0), p);
        end
        for (int i = 0; i < 6; i++) begin
            p = rand128();
            a_run($sformatf("rt_rand%0d", i), map_state(p, 1'b0), p);
        end

        // 4: backpressure in DONE
        a_out_ready = 1'b0;
        p = rand128();
        a_accept("bp", p);
        a_wait_done("bp", 16);
        hold = a_out_state;
        check("bp_data", hold, map_state(p, 1'b1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!a_out_valid || a_in_ready || !a_busy || a_out_state !== hold) seen++;
        end
        check("bp_stable", 128'(seen), 128'd0);
        a_out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", {126'd0, a_out_valid, a_in_ready}, 128'd1);

        // 5: reset in the middle of RUN
        a_accept("mid", rand128());
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_idle", {125'd0, a_busy, a_in_ready, a_out_valid}, 128'd2);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (a_out_valid) seen++;
        end
        check("mid_no_out", 128'(seen), 128'd0);
        a_run("after_mid", {16{8'h52}}, {16{8'h48}});

        // 6: BPC=4 instance, in_valid held through RUN with changing data
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_state = {16{8'h63}};
        @(posedge clk);
        @(negedge clk);
        b_in_state = rand128();
        check("b_run_not_ready", 128'(b_in_ready), 128'd0);
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b_lat", 128'(lat), 128'd4);
        check("b_data", b_out_state, 128'd0);
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_no_recapture", {126'd0, b_busy, b_out_valid}, 128'd0);

        // BPC=4 random round trips
        for (int i = 0; i < 4; i++) begin
            p = rand128();
            b_in_valid = 1'b1;
            b_in_state = map_state(p, 1'b0);
            @(posedge clk);
            @(negedge clk);
            b_in_valid = 1'b0;
            lat = 0;
            while (!b_out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("b_rt%0d", i), b_out_state, p);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
